// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution tile engine.
//   state_t          - controller states
//   SEL_IFM          - wr_sel code that targets the IFM memory
//   SAT_MAX/SAT_MIN  - int8 saturation limits used by the quantiser
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_QUANT,
    ST_OUT
  } state_t;

  localparam int SEL_IFM = 0;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

endpackage

// File: rtl/pe_mac.sv
// pe_mac: one output channel.
// Each enabled cycle it adds the signed dot product of a LANES-wide int8 word
// pair to its accumulator. On quant_en it registers the accumulator:
// arithmetically shifted right, saturated to int8, and optionally ReLU-clamped.
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   i_clr              clear the accumulator (start of a job)
//   i_mac_en           accumulate i_ifm . i_w this cycle
//   i_ifm, i_w         LANES int8 elements each, lane 0 in bits [7:0]
//   i_quant_en         capture the quantised result
//   i_shift, i_relu    quantiser configuration
//   o_q                registered int8 result
module pe_mac
  import conv_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_mac_en,
  input  logic [LANES*8-1:0] i_ifm,
  input  logic [LANES*8-1:0] i_w,
  input  logic               i_quant_en,
  input  logic [4:0]         i_shift,
  input  logic               i_relu,
  output logic [7:0]         o_q
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  logic signed [15:0]      w_prod [LANES];
  logic signed [ACC_W-1:0] w_dot;
  logic signed [ACC_W-1:0] w_shifted;
  logic [7:0]              w_q;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_q;

  // int8 x int8 always fits in 16 bits, so sign-extend and truncate.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [15:0] w_a;
    logic signed [15:0] w_b;
    assign w_a = {{8{i_ifm[8*gi+7]}}, i_ifm[8*gi +: 8]};
    assign w_b = {{8{i_w[8*gi+7]}}, i_w[8*gi +: 8]};
    assign w_prod[gi] = w_a * w_b;
  end

  always_comb begin
    w_dot = '0;
    for (int i = 0; i < LANES; i++) begin
      w_dot = w_dot + ACC_W'(w_prod[i]);
    end
  end

  // >>> on a signed operand floors toward minus infinity.
  assign w_shifted = r_acc >>> i_shift;

  always_comb begin
    w_q = w_shifted[7:0];
    if (w_shifted > SAT_HI) begin
      w_q = 8'(SAT_MAX);
    end else if (w_shifted < SAT_LO) begin
      w_q = 8'(SAT_MIN);
    end
    if (i_relu && w_shifted[ACC_W-1]) begin
      w_q = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_q   <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_mac_en) begin
        r_acc <= r_acc + w_dot;  // wraps at ACC_W bits
      end
      if (i_quant_en) begin
        r_q <= w_q;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/conv_tile_engine.sv
// conv_tile_engine: NUM_PE output channels sharing one IFM stream.
// A job streams cfg_len words from the IFM memory and from every PE's weight
// memory, accumulates the dot products, quantises, and presents one int8
// per PE on a valid/ready handshake.
// Ports:
//   clk, reset                     clock / synchronous active-high reset
//   wr_en, wr_sel, wr_addr,        memory write port (IDLE only);
//   wr_data, wr_drop               wr_drop pulses for a rejected write
//   cfg_len, cfg_ifm_base,         job configuration, captured on an
//   cfg_w_base, cfg_shift,         accepted start
//   cfg_relu
//   start, busy                    job request / job in progress
//   ofm_valid, ofm_ready, ofm_data result handshake, PE p in [8p+7:8p]
module conv_tile_engine
  import conv_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int LANES  = 4,
  parameter int DEPTH  = 128,
  parameter int ACC_W  = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int SELW  = $clog2(NUM_PE + 1),
  localparam int WW    = LANES * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WW-1:0]     wr_data,
  input  logic [AW:0]       cfg_len,
  input  logic [AW-1:0]     cfg_ifm_base,
  input  logic [AW-1:0]     cfg_w_base,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic              start,
  output logic              busy,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [NUM_PE*8-1:0] ofm_data,
  output logic              wr_drop
);

  state_t r_state, w_state_next;

  logic          w_start_acc;
  logic          w_rd_en;
  logic          w_quant_en;
  logic          w_wr_ok;
  logic [AW:0]   r_remain;
  logic [AW-1:0] r_ifm_addr;
  logic [AW-1:0] r_w_addr;
  logic [4:0]    r_shift;
  logic          r_relu;
  logic          r_mac_en;
  logic          r_wr_drop;
  logic [WW-1:0] r_ifm_mem [DEPTH];
  logic [WW-1:0] r_ifm_rdata;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = (cfg_len != '0) ? ST_FETCH : ST_DRAIN;
      ST_FETCH: if (r_remain == {{AW{1'b0}}, 1'b1}) w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_QUANT;
      ST_QUANT: w_state_next = ST_OUT;
      ST_OUT:   if (ofm_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (r_state != ST_IDLE);
    ofm_valid   = (r_state == ST_OUT);
    w_start_acc = (r_state == ST_IDLE) && start;
    w_rd_en     = (r_state == ST_FETCH);
    w_quant_en  = (r_state == ST_QUANT);
  end

  // Writes land only while idle and only for an existing target.
  assign w_wr_ok = wr_en && (r_state == ST_IDLE) && (wr_sel <= SELW'(NUM_PE));

  // ---------------- job sequencing ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain   <= '0;
      r_ifm_addr <= '0;
      r_w_addr   <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_mac_en   <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && !w_wr_ok;
      // Read data arrives one cycle after the FETCH address, so the MAC
      // enable is the FETCH flag delayed by one cycle.
      r_mac_en  <= w_rd_en;
      if (w_start_acc) begin
        r_remain   <= cfg_len;
        r_ifm_addr <= cfg_ifm_base;
        r_w_addr   <= cfg_w_base;
        r_shift    <= cfg_shift;
        r_relu     <= cfg_relu;
      end else if (w_rd_en) begin
        r_remain   <= r_remain - 1'b1;
        r_ifm_addr <= (r_ifm_addr == AW'(DEPTH - 1)) ? '0 : r_ifm_addr + 1'b1;
        r_w_addr   <= (r_w_addr == AW'(DEPTH - 1)) ? '0 : r_w_addr + 1'b1;
      end
    end
  end

  assign wr_drop = r_wr_drop;

  // ---------------- IFM memory (contents survive reset) ----------------
  always_ff @(posedge clk) begin
    if (w_wr_ok && wr_sel == SELW'(SEL_IFM)) r_ifm_mem[wr_addr] <= wr_data;
    if (w_rd_en) r_ifm_rdata <= r_ifm_mem[r_ifm_addr];
  end

  // ---------------- per-PE weight memory and MAC ----------------
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    logic [WW-1:0] r_w_mem [DEPTH];
    logic [WW-1:0] r_w_rdata;

    always_ff @(posedge clk) begin
      if (w_wr_ok && wr_sel == SELW'(gi + 1)) r_w_mem[wr_addr] <= wr_data;
      if (w_rd_en) r_w_rdata <= r_w_mem[r_w_addr];
    end

    pe_mac #(
      .LANES (LANES),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_start_acc),
      .i_mac_en   (r_mac_en),
      .i_ifm      (r_ifm_rdata),
      .i_w        (r_w_rdata),
      .i_quant_en (w_quant_en),
      .i_shift    (r_shift),
      .i_relu     (r_relu),
      .o_q        (ofm_data[8*gi +: 8])
    );
  end

endmodule

// File: tb/tb_conv_tile_engine.sv
module tb_conv_tile_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_sel = '0;
  logic [6:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [7:0]   cfg_len = '0;
  logic [6:0]   cfg_ifm_base = '0;
  logic [6:0]   cfg_w_base = '0;
  logic [4:0]   cfg_shift = '0;
  logic         cfg_relu = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         ofm_valid;
  logic         ofm_ready = 1'b0;
  logic [127:0] ofm_data;
  logic         wr_drop;

  int errors = 0;
  int checks = 0;

  conv_tile_engine dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cfg_len      (cfg_len),
    .cfg_ifm_base (cfg_ifm_base),
    .cfg_w_base   (cfg_w_base),
    .cfg_shift    (cfg_shift),
    .cfg_relu     (cfg_relu),
    .start        (start),
    .busy         (busy),
    .ofm_valid    (ofm_valid),
    .ofm_ready    (ofm_ready),
    .ofm_data     (ofm_data),
    .wr_drop      (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [4:0] sel, input logic [6:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] len, input logic [6:0] ib, input logic [6:0] wb,
                         input logic [4:0] sh, input logic relu);
    cfg_len = len; cfg_ifm_base = ib; cfg_w_base = wb; cfg_shift = sh; cfg_relu = relu;
  endtask

  // Waits (bounded) for ofm_valid; lat counts edges from the accept edge inclusive.
  task automatic wait_valid(inout int lat);
    while (!ofm_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    ofm_ready = 1'b1;
    tick();
    ofm_ready = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] len, input logic [6:0] ib, input logic [6:0] wb,
                         input logic [4:0] sh, input logic relu,
                         output int lat, output logic [127:0] data);
    set_cfg(len, ib, wb, sh, relu);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    wait_valid(lat);
    data = ofm_data;
    if (ofm_valid) handshake();
    $display("job len=%0d ifm=%0d w=%0d sh=%0d relu=%0d -> lat=%0d pe0=%02h pe1=%02h",
             len, ib, wb, sh, relu, lat, data[7:0], data[15:8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (ofm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ofm_valid); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b expected 0", wr_drop); end
    checks++; if (ofm_data !== 128'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", ofm_data); end
    reset = 1'b0;
    tick();
    $display("reset done busy=%0b valid=%0b", busy, ofm_valid);
  endtask

  task automatic test_basic();
    int lat;
    logic [127:0] d;
    mem_write(5'd0, 7'd0, 32'h04030201);
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL basic_nodrop: got %0b expected 0", wr_drop); end
    mem_write(5'd1, 7'd0, 32'h01010101);
    mem_write(5'd2, 7'd0, 32'hFFFFFFFF);
    run_job(8'd1, 7'd0, 7'd0, 5'd0, 1'b0, lat, d);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (d[7:0] !== 8'h0A) begin errors++; $display("FAIL basic_pe0: got %02h expected 0a", d[7:0]); end
    checks++; if (d[15:8] !== 8'hF6) begin errors++; $display("FAIL basic_pe1: got %02h expected f6", d[15:8]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_zero_len();
    int lat;
    logic [127:0] d;
    run_job(8'd0, 7'd0, 7'd0, 5'd0, 1'b0, lat, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency: got %0d expected 3", lat); end
    checks++; if (d[15:0] !== 16'h0000) begin errors++; $display("FAIL zero_data: got %04h expected 0000", d[15:0]); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      mem_write(5'd0, 7'(10 + i), 32'h7F7F7F7F);
      mem_write(5'd1, 7'(10 + i), 32'h7F7F7F7F);
      mem_write(5'd1, 7'(20 + i), 32'h81818181);
    end
    run_job(8'd4, 7'd10, 7'd10, 5'd0, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %02h expected 7f", d[7:0]); end
    run_job(8'd4, 7'd10, 7'd20, 5'd0, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h80) begin errors++; $display("FAIL sat_neg: got %02h expected 80", d[7:0]); end
    run_job(8'd4, 7'd10, 7'd20, 5'd0, 1'b1, lat, d);
    checks++; if (d[7:0] !== 8'h00) begin errors++; $display("FAIL sat_relu: got %02h expected 00", d[7:0]); end
    // 258064 >>> 11 = 126 ; -258064 >>> 11 = floor(-126.008) = -127
    run_job(8'd4, 7'd10, 7'd10, 5'd11, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h7E) begin errors++; $display("FAIL shift_pos: got %02h expected 7e", d[7:0]); end
    run_job(8'd4, 7'd10, 7'd20, 5'd11, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h81) begin errors++; $display("FAIL shift_floor: got %02h expected 81", d[7:0]); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL sat_latency: got %0d expected 7", lat); end
  endtask

  task automatic load_wrap_data();
    mem_write(5'd0, 7'd125, 32'h64646464);
    mem_write(5'd0, 7'd126, 32'h01010101);
    mem_write(5'd0, 7'd127, 32'h02020202);
    mem_write(5'd0, 7'd0,   32'h03030303);
    mem_write(5'd0, 7'd1,   32'h04040404);
    mem_write(5'd0, 7'd2,   32'h64646464);
    mem_write(5'd1, 7'd125, 32'h64646464);
    mem_write(5'd1, 7'd126, 32'h01010101);
    mem_write(5'd1, 7'd127, 32'h02020202);
    mem_write(5'd1, 7'd0,   32'hFFFFFFFF);
    mem_write(5'd1, 7'd1,   32'h03030303);
    mem_write(5'd1, 7'd2,   32'h64646464);
  endtask

  // 4*(1*1 + 2*2 + 3*(-1) + 4*3) = 56
  task automatic test_wrap();
    int lat;
    logic [127:0] d;
    load_wrap_data();
    run_job(8'd4, 7'd126, 7'd126, 5'd0, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h38) begin errors++; $display("FAIL wrap_sum: got %02h expected 38", d[7:0]); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL wrap_latency: got %0d expected 7", lat); end
  endtask

  task automatic test_reset_midjob();
    int lat;
    logic [127:0] d;
    set_cfg(8'd4, 7'd126, 7'd126, 5'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
    checks++; if (ofm_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b expected 0", ofm_valid); end
    checks++; if (ofm_data !== 128'd0) begin errors++; $display("FAIL midreset_data: got %h expected 0", ofm_data); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_stay: got %0b expected 0", busy); end
    run_job(8'd4, 7'd126, 7'd126, 5'd0, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h38) begin errors++; $display("FAIL midreset_rerun: got %02h expected 38", d[7:0]); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL midreset_latency: got %0d expected 7", lat); end
  endtask

  // IFM[40]={5,5,5,5}, W0[40]={2,2,2,2} -> 40
  task automatic test_write_drop();
    int lat;
    logic [127:0] d;
    mem_write(5'd0, 7'd40, 32'h05050505);
    mem_write(5'd1, 7'd40, 32'h02020202);
    set_cfg(8'd1, 7'd40, 7'd40, 5'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_sel = 5'd0; wr_addr = 7'd40; wr_data = 32'h7F7F7F7F;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b expected 1", wr_drop); end
    tick();
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_single: got %0b expected 0", wr_drop); end
    lat = 3;
    wait_valid(lat);
    checks++; if (ofm_data[7:0] !== 8'h28) begin errors++; $display("FAIL drop_job: got %02h expected 28", ofm_data[7:0]); end
    if (ofm_valid) handshake();
    run_job(8'd1, 7'd40, 7'd40, 5'd0, 1'b0, lat, d);
    checks++; if (d[7:0] !== 8'h28) begin errors++; $display("FAIL drop_mem_kept: got %02h expected 28", d[7:0]); end
  endtask

  task automatic test_bad_sel();
    mem_write(5'd17, 7'd40, 32'h7F7F7F7F);
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL badsel_pulse: got %0b expected 1", wr_drop); end
    tick();
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL badsel_single: got %0b expected 0", wr_drop); end
    $display("bad sel write rejected");
  endtask

  // W0[50]={7,..}; IFM[50] rewritten from {1,..} to {2,..} in the start cycle -> 56
  task automatic test_same_cycle();
    int lat;
    mem_write(5'd1, 7'd50, 32'h07070707);
    mem_write(5'd0, 7'd50, 32'h01010101);
    set_cfg(8'd1, 7'd50, 7'd50, 5'd0, 1'b0);
    start = 1'b1;
    wr_en = 1'b1; wr_sel = 5'd0; wr_addr = 7'd50; wr_data = 32'h02020202;
    tick();
    start = 1'b0; wr_en = 1'b0;
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL same_nodrop: got %0b expected 0", wr_drop); end
    lat = 1;
    wait_valid(lat);
    checks++; if (ofm_data[7:0] !== 8'h38) begin errors++; $display("FAIL same_newdata: got %02h expected 38", ofm_data[7:0]); end
    if (ofm_valid) handshake();
    $display("same-cycle write+start pe0=%02h", ofm_data[7:0]);
  endtask

  task automatic test_backpressure();
    int lat;
    set_cfg(8'd1, 7'd50, 7'd50, 5'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ofm_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b expected 1", i, ofm_valid); end
      checks++; if (ofm_data[7:0] !== 8'h38) begin errors++; $display("FAIL bp_stable[%0d]: got %02h expected 38", i, ofm_data[7:0]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %0b expected 1", i, busy); end
      if (i == 2) begin
        set_cfg(8'd0, 7'd0, 7'd0, 5'd0, 1'b0);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    handshake();
    checks++; if (ofm_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got %0b expected 0", ofm_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %0b expected 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: got %0b expected 0", busy); end
    $display("backpressure held 5 cycles, pe0=%02h", ofm_data[7:0]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_saturation();
    test_wrap();
    test_reset_midjob();
    test_write_drop();
    test_bad_sel();
    test_same_cycle();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
